// File: rtl/seven_seg_capture.sv
// Seven-segment bus observer: synchronises the scanned segment/strobe lines,
// dwell-filters each digit, decodes it to BCD and publishes complete frames.
module seven_seg_capture #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  digit_en,
  output logic [15:0] value,
  output logic [3:0]  blank,
  output logic [3:0]  err,
  output logic        frame_valid
);
  localparam int NUM_LANES = 4;
  localparam int VEC_W     = 4;
  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  typedef struct packed {
    logic             blank;
    logic             err;
    logic [VEC_W-1:0] nib;
  } dec_t;

  logic [6:0]           seg_s1, seg_s2;
  logic [NUM_LANES-1:0] en_s1, en_s2;
  logic [7:0]           cnt;
  logic                 captured;
  logic [NUM_LANES-1:0] seen;
  logic                 same, onehot, cap, frame_done;
  dec_t                 dec;

  logic [NUM_LANES-1:0][VEC_W-1:0] stg_val;
  logic [NUM_LANES-1:0]            stg_blank, stg_err;

  function automatic dec_t decode(input logic [6:0] s);
    dec_t d;
    d = '{blank: 1'b0, err: 1'b0, nib: 4'h0};
    case (s)
      7'h3F: d.nib = 4'd0;
      7'h06: d.nib = 4'd1;
      7'h5B: d.nib = 4'd2;
      7'h4F: d.nib = 4'd3;
      7'h66: d.nib = 4'd4;
      7'h6D: d.nib = 4'd5;
      7'h7D: d.nib = 4'd6;
      7'h07: d.nib = 4'd7;
      7'h7F: d.nib = 4'd8;
      7'h6F: d.nib = 4'd9;
      7'h00: begin d.nib = 4'hF; d.blank = 1'b1; end
      default: begin d.nib = 4'hE; d.err = 1'b1; end
    endcase
    return d;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1 <= '0; seg_s2 <= '0;
      en_s1  <= '0; en_s2  <= '0;
    end else begin
      seg_s1 <= seg_in;   seg_s2 <= seg_s1;
      en_s1  <= digit_en; en_s2  <= en_s1;
    end
  end

  // cnt tracks how many cycles the synchronised sample (seg_s2/en_s2) will
  // have held its value after this edge, so the change is seen one flop early.
  assign same       = {en_s1, seg_s1} == {en_s2, seg_s2};
  assign onehot     = (en_s1 != '0) && ((en_s1 & (en_s1 - 1'b1)) == '0);
  assign cap        = same && onehot && !captured && (cnt == STABLE - 8'd1);
  assign frame_done = &seen;
  assign dec        = decode(seg_s2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      captured <= 1'b0;
    end else if (!onehot) begin
      cnt      <= '0;
      captured <= 1'b0;
    end else if (!same) begin
      cnt      <= 8'd1;
      captured <= 1'b0;
    end else begin
      if (cnt != STABLE) cnt <= cnt + 8'd1;
      if (cap) captured <= 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stg_val[i]   <= '0;
        stg_blank[i] <= 1'b0;
        stg_err[i]   <= 1'b0;
      end else if (cap && en_s2[i]) begin
        stg_val[i]   <= dec.nib;
        stg_blank[i] <= dec.blank;
        stg_err[i]   <= dec.err;
      end
    end
  end

  // A capture on the completion edge starts the next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen        <= '0;
      value       <= '0;
      blank       <= '0;
      err         <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= frame_done;
      if (frame_done) begin
        value <= stg_val;
        blank <= stg_blank;
        err   <= stg_err;
        seen  <= cap ? en_s2 : '0;
      end else if (cap) begin
        seen  <= seen | en_s2;
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: stimulus pushes expected frames,
// a negedge monitor pops and compares on every frame_valid pulse.
module tb_seven_seg_capture;
  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  digit_en = '0;
  logic [15:0] value;
  logic [3:0]  blank, err;
  logic        frame_valid;

  int checks = 0;
  int errors = 0;
  int nframes = 0;
  logic fv_prev = 1'b0;
  logic [23:0] expq[$];

  seven_seg_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .digit_en(digit_en),
    .value(value), .blank(blank), .err(err), .frame_valid(frame_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic drive(input logic [3:0] en, input logic [6:0] seg, input int n);
    digit_en = en;
    seg_in   = seg;
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [15:0] v, input logic [3:0] b, input logic [3:0] e);
    expq.push_back({v, b, e});
  endtask

  always @(negedge clk) begin
    if (frame_valid) begin
      nframes++;
      chk("fv_consecutive", {31'd0, fv_prev}, 32'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got value=%h blank=%b err=%b, expected no frame",
                 value, blank, err);
      end else begin
        logic [23:0] e;
        e = expq.pop_front();
        chk("frame", {8'd0, value, blank, err}, {8'd0, e});
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int nf;
    repeat (3) @(negedge clk);
    chk("reset_value", {16'd0, value}, 32'h0);
    chk("reset_flags", {23'd0, blank, err, frame_valid}, 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Normal scan, with latency measured on the final digit
    drive(4'b0001, 7'h06, 8);
    drive(4'b0010, 7'h5B, 8);
    drive(4'b0100, 7'h4F, 8);
    push(16'h4321, 4'h0, 4'h0);
    digit_en = 4'b1000; seg_in = 7'h66;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (frame_valid && lat == 0) lat = i;
    end
    chk("frame_latency", lat, S + 2);
    drive(4'b0000, 7'h00, 10);
    chk("hold_value", {16'd0, value}, 32'h4321);

    // Short dwell on digit 1 is ignored; a later full dwell completes the frame
    drive(4'b0010, 7'h6D, S - 1);
    drive(4'b0100, 7'h5B, 8);
    drive(4'b1000, 7'h4F, 8);
    drive(4'b0001, 7'h06, 8);
    drive(4'b0000, 7'h00, 6);
    push(16'h3281, 4'h0, 4'h0);
    drive(4'b0010, 7'h7F, 8);
    drive(4'b0000, 7'h00, 6);

    // Blank and error digits
    drive(4'b0001, 7'h77, 8);
    drive(4'b0010, 7'h3F, 8);
    drive(4'b0100, 7'h3F, 8);
    push(16'hF00E, 4'b1000, 4'b0001);
    drive(4'b1000, 7'h00, 8);
    drive(4'b0000, 7'h00, 6);

    // Non-one-hot strobe is never captured
    nf = nframes;
    drive(4'b0011, 7'h06, 20);
    drive(4'b0000, 7'h00, 4);
    chk("bad_strobe_noframe", nframes, nf);
    drive(4'b0001, 7'h6F, 8);
    drive(4'b0010, 7'h7F, 8);
    drive(4'b0100, 7'h07, 8);
    push(16'h6789, 4'h0, 4'h0);
    drive(4'b1000, 7'h7D, 8);
    drive(4'b0000, 7'h00, 6);

    // Overwrite digit 0: last capture wins, one frame only
    nf = nframes;
    drive(4'b0001, 7'h6D, 8);
    drive(4'b0001, 7'h7F, 8);
    drive(4'b0010, 7'h06, 8);
    drive(4'b0100, 7'h5B, 8);
    push(16'h3218, 4'h0, 4'h0);
    drive(4'b1000, 7'h4F, 8);
    drive(4'b0000, 7'h00, 6);
    chk("overwrite_one_frame", nframes - nf, 1);

    // Reset mid-frame discards the partial frame
    nf = nframes;
    drive(4'b0001, 7'h06, 8);
    drive(4'b0010, 7'h5B, 8);
    drive(4'b0100, 7'h4F, 8);
    drive(4'b1000, 7'h66, 2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midreset_value", {16'd0, value}, 32'h0);
    chk("midreset_flags", {23'd0, blank, err, frame_valid}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(4'b1000, 7'h66, 8);
    drive(4'b0000, 7'h00, 10);
    chk("midreset_noframe", nframes, nf);
    chk("post_reset_value", {16'd0, value}, 32'h0);
    chk("post_reset_flags", {24'd0, blank, err}, 32'h0);

    chk("frames_total", nframes, 5);
    chk("queue_drained", expq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Recovers BCD digits from a multiplexed, active-high seven-segment bus (segment A on bit 0 through G on bit 6, digits 0-9, blank for non-decimal). Four one-hot digit strobes are sampled, dwell-filtered against ghosting and decoded back to 4-bit values. Complete four-digit frames are presented as a 16-bit word. The block sits on the observer side of a scanned display, as a board self-test or display sniffer.

## Interface
- `STABLE_CYCLES`, default 4: consecutive identical synchronised samples required before a digit is captured. Legal range is 2 to 255.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `seg_in` input 7: segment lines, active-high, with bit 0 = A through bit 6 = G. Asynchronous to `clk`.
- `digit_en` input 4: digit strobes, active-high, one-hot when valid. Bit i selects digit i. Asynchronous to `clk`.
- `value` output 16: last complete frame. Digit i is in `value[4i+3:4i]`.
- `blank` output 4: per-digit flag for the last frame; set means the digit was all-segments-off.
- `err` output 4: per-digit flag for the last frame; set means the pattern was unrecognised.
- `frame_valid` output 1: one-cycle pulse when `value`, `blank` and `err` update.

## Operation
- **Synchroniser:** `seg_in` and `digit_en` each pass through a 2-flop synchroniser. All further logic uses only the synchronised 11-bit sample.
- **Dwell filter:**
  - An 8-bit counter compares each sample with the previous one.
  - If the sample is identical, the counter increments and saturates at `STABLE_CYCLES`.
  - If the sample differs, the counter loads 1 and the per-dwell `captured` flag clears.
  - If the synchronised strobe is not one-hot (0000 or more than one bit set), the counter holds 0 and no capture occurs.
- **Capture:** one capture per dwell, on the edge where the counter reaches `STABLE_CYCLES`. The strobe must be one-hot and `captured` must be 0; capture then sets `captured`.
- **Decode** (pattern shown as G..A hex):
  - 0x3F→0, 0x06→1, 0x5B→2, 0x4F→3, 0x66→4, 0x6D→5, 0x7D→6, 0x07→7, 0x7F→8, 0x6F→9.
  - 0x00 → nibble F with the staging blank bit set.
  - Any other pattern → nibble E with the staging err bit set.
- **Staging:**
  - A capture writes staging nibble i plus its blank and err bits, and sets `seen[i]`.
  - Recapturing a digit already in `seen` overwrites it; the last capture wins.
- **Frame completion:**
  - On the edge after `seen` becomes 4'hF, staging is copied to `value`, `blank` and `err`, `frame_valid` pulses, and `seen` clears.
  - If a capture happens on that same edge, it writes staging and sets its `seen` bit after the clear, so it counts toward the next frame.
- **Reset:** asynchronous. It clears the synchronisers, counter, `captured`, staging, `seen` and all outputs. A partial frame is discarded.

## Timing
- Reset values: `value`=16'h0000, `blank`=4'h0, `err`=4'h0, `frame_valid`=0.
- Reference point: edge 1 is the first edge that registers a new, held input.
  - Synchroniser output is valid at edge 2.
  - Capture happens at edge `STABLE_CYCLES`+1.
  - If that capture completes a frame, the outputs update and `frame_valid` is high after edge `STABLE_CYCLES`+2.
- Minimum dwell for capture: `STABLE_CYCLES` synchronised cycles.
  - A dwell of `STABLE_CYCLES`-1 cycles or fewer is never captured.
  - A dwell longer than `STABLE_CYCLES` is captured once only.
- `frame_valid` is never high on two consecutive cycles.
- Outputs hold their values between frames.

## Test plan
- **Normal scan:** `STABLE_CYCLES`=4. Scan digit_en 0001/0010/0100/1000 with seg 0x06/0x5B/0x4F/0x66, 8 cycles each → one `frame_valid` pulse, `value`=16'h4321, `blank`=0, `err`=0.
- **Short dwell:** digit 1 held for 3 cycles, then digits 2, 3, 0 normally → no `frame_valid`. A later 8-cycle dwell on digit 1 with 0x7F → `value` nibble 1 = 8 and the frame completes.
- **Blank and error:** digit 3 with seg 0x00 and digit 0 with seg 0x77; digits 1 and 2 hold 0x3F → `value`=16'hF00E, `blank`=4'b1000, `err`=4'b0001.
- **Bad strobe:** digit_en=0011 held for 20 cycles → no capture and `seen` unchanged. Then a normal frame of 9,8,7,6 → `value`=16'h6789.
- **Overwrite:** digit 0 captured with 0x6D, then again with 0x7F, then digits 1-3 → nibble 0 = 8 and exactly one `frame_valid`.
- **Reset mid-frame:** capture digits 0-2, pulse `rst_n` low mid-dwell on digit 3, then capture digit 3 only → outputs stay at reset values and no `frame_valid`.
